// File: rtl/coord_table_reader.sv
// ============================================================================
// coord_table_reader: walks an async-read (x,y) table and streams entries out
// Rev 1.0
// ============================================================================
`default_nettype none

module coord_table_reader #(
   parameter int DEPTH = 9,
   parameter int DW    = 8,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          loop,
   input  logic          abort,
   output logic [AW-1:0] tbl_addr,
   input  logic [DW-1:0] tbl_x,
   input  logic [DW-1:0] tbl_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_x,
   output logic [DW-1:0] out_y,
   output logic [AW-1:0] out_idx,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_x_q, out_x_d;
   logic [DW-1:0] out_y_q, out_y_d;
   logic [AW-1:0] out_idx_q, out_idx_d;
   logic          out_last_q, out_last_d;
   logic          done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;

      // abort outranks both start and a same-cycle handshake
      if (abort) begin
         state_d     = S_IDLE;
         idx_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_FETCH;
                  idx_d   = '0;
               end
            end
            S_FETCH: begin
               out_x_d     = tbl_x;
               out_y_d     = tbl_y;
               out_idx_d   = idx_q;
               out_last_d  = (idx_q == LAST_IDX);
               out_valid_d = 1'b1;
               state_d     = S_SEND;
            end
            S_SEND: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  if (idx_q != LAST_IDX) begin
                     idx_d   = idx_q + AW'(1);
                     state_d = S_FETCH;
                  end else if (loop) begin
                     idx_d   = '0;
                     state_d = S_FETCH;
                  end else begin
                     idx_d   = '0;
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d     = S_IDLE;
               idx_d       = '0;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   assign tbl_addr  = idx_q;
   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;

endmodule

`default_nettype wire
